// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer slice.
// Holds the sequencer state encoding and the default layer geometry
// (inputs per neuron, neurons per layer) used as parameter defaults.
package layer_seq_pkg;

  localparam int N_IN_DEFAULT  = 784;
  localparam int N_OUT_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } layer_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Control/address bundle between the layer sequencer and its environment.
// Signals:
//   start    request to run one full layer (single-cycle pulse, sampled only in IDLE)
//   busy     high from the first CLEAR cycle through the DONE cycle
//   done     one-cycle completion pulse
//   in_addr  input-vector RAM read address
//   w_addr   weight RAM read address
//   acc_clr  accumulator clear / load-select
//   acc_en   MAC accumulate enable (aligned to 1-cycle RAM read data)
//   out_wr   result RAM write strobe
//   out_addr result RAM write address (neuron index)
//   state    current sequencer state, exported for observation
// Handshake: start is a request with no ready; it is honoured only when the
// sequencer is idle (busy=0) and is ignored otherwise. done marks the end.
interface layer_sequencer_if #(
  parameter int N_IN  = layer_seq_pkg::N_IN_DEFAULT,
  parameter int N_OUT = layer_seq_pkg::N_OUT_DEFAULT
);
  import layer_seq_pkg::*;

  localparam int IW = $clog2(N_IN);
  localparam int WW = $clog2(N_IN * N_OUT);
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] in_addr;
  logic [WW-1:0] w_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_wr;
  logic [OW-1:0] out_addr;
  layer_state_t  state;

  modport master (
    input  start,
    output busy, done, in_addr, w_addr, acc_clr, acc_en, out_wr, out_addr, state
  );

  modport slave (
    output start,
    input  busy, done, in_addr, w_addr, acc_clr, acc_en, out_wr, out_addr, state
  );

endinterface

// File: rtl/seq_counter.sv
// Up-counter used for every address / index in the sequencer.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   clr       synchronous clear to 0 (below rst, above en)
//   en        count enable
//   count     current value
//   tc        terminal-count flag, high while count == LAST
module seq_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer: for each neuron it clears the
// accumulator, streams N_IN input/weight address pairs, waits one cycle for
// the last RAM read to land, then writes the result.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  layer_sequencer_if master side (start in; strobes, addresses, state out)
module layer_sequencer #(
  parameter int N_IN  = layer_seq_pkg::N_IN_DEFAULT,
  parameter int N_OUT = layer_seq_pkg::N_OUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  layer_sequencer_if.master bus
);
  import layer_seq_pkg::*;

  localparam int IW = $clog2(N_IN);
  localparam int WW = $clog2(N_IN * N_OUT);
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  layer_state_t  state;
  layer_state_t  next_state;
  logic          run_start;
  logic          in_tc;
  logic          w_tc;
  logic          n_tc;
  logic          acc_en_q;
  logic [IW-1:0] in_cnt;
  logic [WW-1:0] w_cnt;
  logic [OW-1:0] n_cnt;

  assign run_start = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = CLEAR;
      CLEAR:   next_state = MAC;
      MAC:     if (in_tc) next_state = DRAIN;
      DRAIN:   next_state = WRITE;
      WRITE:   next_state = n_tc ? DONE : CLEAR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Input address restarts every neuron and stops on N_IN-1 so it holds its
  // last value outside MAC. Clearing on run start as well keeps the first
  // CLEAR cycle of a run at 0.
  seq_counter #(.WIDTH(IW), .LAST(IW'(N_IN - 1))) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_start || (state == CLEAR)),
    .en    ((state == MAC) && !in_tc),
    .count (in_cnt),
    .tc    (in_tc)
  );

  // Weight address runs across neurons so it sits at neuron*N_IN on entry.
  // It freezes on the final address of the layer instead of wrapping, and is
  // only returned to 0 when the next run starts.
  seq_counter #(.WIDTH(WW), .LAST(WW'(N_IN * N_OUT - 1))) u_w_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_start),
    .en    ((state == MAC) && !w_tc),
    .count (w_cnt),
    .tc    (w_tc)
  );

  seq_counter #(.WIDTH(OW), .LAST(OW'(N_OUT - 1))) u_n_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_start),
    .en    ((state == WRITE) && !n_tc),
    .count (n_cnt),
    .tc    (n_tc)
  );

  // Read data arrives one cycle after the address, so the accumulate enable
  // is the MAC-state qualifier delayed by one cycle (covers the DRAIN cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_en_q <= 1'b0;
    end else begin
      acc_en_q <= (state == MAC);
    end
  end

  assign bus.state    = state;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.acc_clr  = (state == CLEAR);
  assign bus.acc_en   = acc_en_q;
  assign bus.out_wr   = (state == WRITE);
  assign bus.in_addr  = in_cnt;
  assign bus.w_addr   = w_cnt;
  assign bus.out_addr = n_cnt;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a 4x3 instance and a 2x1 instance.
// Expected per-cycle values come from a small timing model of the layer walk.
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_sequencer_if #(.N_IN(4), .N_OUT(3)) bus_a ();
  layer_sequencer_if #(.N_IN(2), .N_OUT(1)) bus_b ();

  layer_sequencer #(.N_IN(4), .N_OUT(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  layer_sequencer #(.N_IN(2), .N_OUT(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // c = cycles since the edge that sampled start (c=1 is the first CLEAR).
  // c=0 means freshly reset and idle.
  task automatic model(input int ni, input int no, input int c,
                       output layer_state_t st, output int ia, output int wa,
                       output int oa, output logic ae);
    int per;
    int tot;
    int n;
    int p;
    per = ni + 3;
    tot = no * per;
    st = IDLE; ia = 0; wa = 0; oa = 0; ae = 1'b0;
    if (c == 0) begin
      st = IDLE;
    end else if (c > tot) begin
      st = (c == tot + 1) ? DONE : IDLE;
      ia = ni - 1;
      wa = ni * no - 1;
      oa = no - 1;
    end else begin
      n  = (c - 1) / per;
      p  = (c - 1) % per;
      oa = n;
      if (p == 0) begin
        st = CLEAR;
        ia = (n == 0) ? 0 : ni - 1;
        wa = n * ni;
      end else if (p <= ni) begin
        st = MAC;
        ia = p - 1;
        wa = n * ni + p - 1;
        ae = (p >= 2);
      end else begin
        st = (p == ni + 1) ? DRAIN : WRITE;
        ia = ni - 1;
        wa = (n == no - 1) ? ni * no - 1 : (n + 1) * ni;
        ae = (p == ni + 1);
      end
    end
  endtask

  task automatic check_a(input string tag, input int c);
    layer_state_t st;
    int ia, wa, oa;
    logic ae;
    model(4, 3, c, st, ia, wa, oa, ae);
    chk($sformatf("%s c%0d state", tag, c), 32'(bus_a.state), 32'(st));
    chk($sformatf("%s c%0d in_addr", tag, c), 32'(bus_a.in_addr), 32'(ia));
    chk($sformatf("%s c%0d w_addr", tag, c), 32'(bus_a.w_addr), 32'(wa));
    chk($sformatf("%s c%0d out_addr", tag, c), 32'(bus_a.out_addr), 32'(oa));
    chk($sformatf("%s c%0d acc_clr", tag, c), 32'(bus_a.acc_clr), 32'(st == CLEAR));
    chk($sformatf("%s c%0d acc_en", tag, c), 32'(bus_a.acc_en), 32'(ae));
    chk($sformatf("%s c%0d out_wr", tag, c), 32'(bus_a.out_wr), 32'(st == WRITE));
    chk($sformatf("%s c%0d done", tag, c), 32'(bus_a.done), 32'(st == DONE));
    chk($sformatf("%s c%0d busy", tag, c), 32'(bus_a.busy), 32'(st != IDLE));
  endtask

  task automatic check_b(input string tag, input int c);
    layer_state_t st;
    int ia, wa, oa;
    logic ae;
    model(2, 1, c, st, ia, wa, oa, ae);
    chk($sformatf("%s c%0d state", tag, c), 32'(bus_b.state), 32'(st));
    chk($sformatf("%s c%0d in_addr", tag, c), 32'(bus_b.in_addr), 32'(ia));
    chk($sformatf("%s c%0d w_addr", tag, c), 32'(bus_b.w_addr), 32'(wa));
    chk($sformatf("%s c%0d out_addr", tag, c), 32'(bus_b.out_addr), 32'(oa));
    chk($sformatf("%s c%0d acc_clr", tag, c), 32'(bus_b.acc_clr), 32'(st == CLEAR));
    chk($sformatf("%s c%0d acc_en", tag, c), 32'(bus_b.acc_en), 32'(ae));
    chk($sformatf("%s c%0d out_wr", tag, c), 32'(bus_b.out_wr), 32'(st == WRITE));
    chk($sformatf("%s c%0d done", tag, c), 32'(bus_b.done), 32'(st == DONE));
    chk($sformatf("%s c%0d busy", tag, c), 32'(bus_b.busy), 32'(st != IDLE));
  endtask

  // Every-cycle invariants on both instances.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("excl_a", 32'((bus_a.acc_clr & bus_a.acc_en) | (bus_a.acc_clr & bus_a.out_wr) |
                        (bus_a.acc_en & bus_a.out_wr)), 32'd0);
      chk("idle_busy_a", 32'((bus_a.state == IDLE) && bus_a.busy), 32'd0);
      chk("excl_b", 32'((bus_b.acc_clr & bus_b.acc_en) | (bus_b.acc_clr & bus_b.out_wr) |
                        (bus_b.acc_en & bus_b.out_wr)), 32'd0);
      chk("idle_busy_b", 32'((bus_b.state == IDLE) && bus_b.busy), 32'd0);
    end
  end

  initial begin
    int wr_cnt;
    int clr_cnt;
    int done_cnt;
    int done_at;

    // Reset, with start asserted during reset: reset must win.
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    bus_a.start = 1'b1;
    step();
    check_a("rst_prio", 0);
    bus_a.start = 1'b0;
    rst = 1'b0;
    mon_on = 1'b1;
    step();
    check_a("reset_a", 0);
    check_b("reset_b", 0);

    // Single run, 4 inputs x 3 neurons: done at start+22.
    wr_cnt = 0; done_at = -1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check_a("run1", c);
      if (bus_a.out_wr === 1'b1) wr_cnt++;
      if (bus_a.done === 1'b1) done_at = c;
      step();
    end
    chk("run1 out_wr count", 32'(wr_cnt), 32'd3);
    chk("run1 done cycle", 32'(done_at), 32'd22);

    // start held high for 40 cycles: one run, one idle cycle, second run.
    done_cnt = 0;
    bus_a.start = 1'b1;
    step();
    for (int c = 1; c <= 50; c++) begin
      if (c == 40) bus_a.start = 1'b0;
      check_a("hold", (c > 23) ? c - 23 : c);
      if (bus_a.done === 1'b1) done_cnt++;
      step();
    end
    chk("hold done count", 32'(done_cnt), 32'd2);

    // Reset on the 3rd MAC cycle of neuron 1 (cycle 11).
    wr_cnt = 0; done_cnt = 0;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_a("abort", c);
      step();
    end
    check_a("abort", 11);
    rst = 1'b1;
    step();
    check_a("abort_rst", 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check_a("abort_idle", 0);
      if (bus_a.out_wr === 1'b1) wr_cnt++;
      if (bus_a.done === 1'b1) done_cnt++;
    end
    chk("abort out_wr count", 32'(wr_cnt), 32'd0);
    chk("abort done count", 32'(done_cnt), 32'd0);

    // Full run after the aborted one.
    done_at = -1;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check_a("run2", c);
      if (bus_a.done === 1'b1) done_at = c;
      step();
    end
    chk("run2 done cycle", 32'(done_at), 32'd22);

    // Smallest layer: 2 inputs x 1 neuron, done at start+6.
    wr_cnt = 0; clr_cnt = 0; done_at = -1;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_b("small", c);
      if (bus_b.out_wr === 1'b1) wr_cnt++;
      if (bus_b.acc_clr === 1'b1) clr_cnt++;
      if (bus_b.done === 1'b1) done_at = c;
      step();
    end
    chk("small out_wr count", 32'(wr_cnt), 32'd1);
    chk("small acc_clr count", 32'(clr_cnt), 32'd1);
    chk("small done cycle", 32'(done_at), 32'd6);

    mon_on = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have parameter N_IN, default 784, the number of inputs per neuron (dot-product length), legal range 2..4096.
REQ-002 The block SHALL have parameter N_OUT, default 10, the number of neurons in the layer, legal range 1..256.
REQ-003 The block SHALL have the following ports.
  clk  in  1  clock; all logic is rising-edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  one-cycle request to run one full layer.
  busy  out  1  high from the first CLEAR cycle through the DONE cycle.
  done  out  1  one-cycle pulse when the layer completes.
  in_addr  out  $clog2(N_IN)  input-vector RAM read address.
  w_addr  out  $clog2(N_IN*N_OUT)  weight RAM read address.
  acc_clr  out  1  accumulator clear/load-select.
  acc_en  out  1  MAC accumulate enable.
  out_wr  out  1  result RAM write strobe.
  out_addr  out  $clog2(N_OUT) (min 1)  result RAM write address (neuron index).

Function
REQ-004 The FSM SHALL have exactly the states IDLE, CLEAR, MAC, DRAIN, WRITE and DONE.
REQ-005 In IDLE, start=1 SHALL move the FSM to CLEAR on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-006 CLEAR SHALL last 1 cycle, SHALL assert acc_clr, SHALL reset in_addr to 0, and SHALL go to MAC.
REQ-007 MAC SHALL last exactly N_IN cycles.
  - in_addr SHALL take the values 0..N_IN-1, one per cycle.
  - w_addr SHALL increment by 1 each MAC cycle.
  - After the cycle with in_addr=N_IN-1, the FSM SHALL go to DRAIN.
REQ-008 acc_en SHALL be the address-issue qualifier delayed by 1 cycle, matching 1-cycle RAM read latency.
  - It SHALL be high for exactly N_IN consecutive cycles: MAC cycles 2..N_IN plus the DRAIN cycle.
REQ-009 DRAIN SHALL last 1 cycle and SHALL go to WRITE.
REQ-010 WRITE SHALL last 1 cycle with out_wr=1 and out_addr equal to the current neuron index.
  - If the neuron index equals N_OUT-1, the FSM SHALL go to DONE.
  - Otherwise the neuron index SHALL increment and the FSM SHALL go to CLEAR.
REQ-011 w_addr SHALL be a running counter (no multiplier).
  - It SHALL be 0 at the start of a run and SHALL be neuron*N_IN at neuron entry.
  - It SHALL not advance outside MAC.
  - It SHALL wrap to 0 only at the start of the next run.
REQ-012 DONE SHALL last 1 cycle with done=1, SHALL deassert busy on the following cycle, and SHALL go to IDLE.
REQ-013 Latency: with start sampled high in cycle t, done SHALL be high in cycle t+1+N_OUT*(N_IN+3).
REQ-014 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-015 acc_clr, acc_en and out_wr SHALL never be high in the same cycle.
REQ-016 When outputs are not active, they SHALL be held as follows:
  - in_addr, w_addr and out_addr hold their last value.
  - Strobes are 0.

Reset
REQ-017 rst=1 SHALL, on the next edge and from any state (including mid-MAC), force:
  - state=IDLE.
  - All counters and addresses 0.
  - busy, done, acc_clr, acc_en and out_wr = 0.
  - The acc_en delay register cleared.
REQ-018 rst SHALL take priority over start in the same cycle.
REQ-019 A run interrupted by rst SHALL NOT produce out_wr or done afterwards.

Structure
REQ-020 Package layer_seq_pkg SHALL hold the state enum typedef and the default N_IN/N_OUT constants.
REQ-021 A single sub-module, seq_counter, SHALL be used for in_addr, w_addr and the neuron index.
  - Its behaviour: parameterised width, synchronous clear, enable, and a terminal-count flag.
REQ-022 All outputs except done SHALL be driven directly from registers or state decode.
  - No combinational path SHALL run from start to any output.

Verification
REQ-023 N_IN=4, N_OUT=3, single start pulse:
  - done SHALL be high exactly 22 cycles after the start cycle.
  - out_wr SHALL be high 3 times, with out_addr=0, 1, 2.
REQ-024 Same configuration:
  - w_addr during MAC SHALL read 0..11 contiguously.
  - in_addr SHALL read 0..3 per neuron.
  - acc_en SHALL be high for 4 cycles per neuron, each window starting 1 cycle after the first MAC cycle.
REQ-025 start held high continuously for 40 cycles:
  - Exactly one run SHALL occur through cycle 22.
  - A second run SHALL begin from IDLE after done.
  - There SHALL be no re-trigger during busy.
REQ-026 rst asserted on the 3rd MAC cycle of neuron 1:
  - Next cycle SHALL show state IDLE, all outputs 0 and no further out_wr.
  - A new start SHALL produce a full 22-cycle run.
REQ-027 N_OUT=1, N_IN=2:
  - done SHALL be high at t+6.
  - out_wr SHALL pulse once, with out_addr=0.
  - acc_clr SHALL be high exactly once.
REQ-028 Every cycle in all runs: assertion that acc_clr, acc_en and out_wr are mutually exclusive, and that busy=0 whenever the state is IDLE.
